mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the memory responder. Holds the FSM
//               state encoding, the byte-to-word address shift and the
//               default parameter values used by mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte address -> word index shift (32-bit words)
  localparam int WORD_SHIFT = 2;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_CYCLES = 2;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Word RAM with synchronous write and registered read. The read
//               port samples addr every cycle; contents are never reset.
// Ports       : clk  - clock, rising edge
//               we   - write enable for the current cycle
//               addr - word index
//               wd   - write data
//               rd   - registered read data (read-before-write)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wd,
  output logic [DATA_W-1:0]        rd
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wd;
    end
    rd_q <= mem_q[addr];
  end

  assign rd = rd_q;

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for the multicycle controller. Accepts
//               one word read/write at a time, waits WAIT_CYCLES states, then
//               returns a one-cycle ready strobe with rd/err. Misaligned or
//               out-of-range addresses respond with err=1, rd=0, no write.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-high
//               req   - access request (held with we/adr/wd until ready)
//               we    - 1 = write, 0 = read
//               adr   - byte address
//               wd    - write data
//               rd    - read data, valid while ready=1, otherwise 0
//               ready - one-cycle response strobe per accepted request
//               err   - error response, valid while ready=1, otherwise 0
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              ready,
  output logic              err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                ready_q, err_q, rd_en_q;
  logic                go_resp;

  // The RAM access happens on the edge that enters RESP. With WAIT_CYCLES=0
  // that edge is also the capture edge, so the live inputs are used while in
  // IDLE and the captured copies otherwise.
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_adr;
  logic [DATA_W-1:0]   acc_wd;
  logic                acc_err;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rd;

  assign acc_we  = (state_q == IDLE) ? we  : we_q;
  assign acc_adr = (state_q == IDLE) ? adr : adr_q;
  assign acc_wd  = (state_q == IDLE) ? wd  : wd_q;

  // Misaligned, or word index >= DEPTH (any bit above the index field set)
  assign acc_err = (|acc_adr[WORD_SHIFT-1:0]) | (|acc_adr[ADDR_W-1:WORD_SHIFT+AW]);
  assign mem_we  = go_resp & acc_we & ~acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d  = we;
          adr_d = adr;
          wd_d  = wd;
          cnt_d = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      ready_q <= go_resp;
      err_q   <= go_resp & acc_err;
      rd_en_q <= go_resp & ~acc_we & ~acc_err;
    end
  end

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (acc_adr[WORD_SHIFT +: AW]),
    .wd   (acc_wd),
    .rd   (mem_rd)
  );

  // RAM read register is gated so rd is 0 outside a successful read response
  assign rd    = mem_rd & {DATA_W{rd_en_q}};
  assign ready = ready_q;
  assign err   = err_q;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder. dut0 uses the default
//               build (WAIT_CYCLES=2), dut1 uses WAIT_CYCLES=0. Stimulus pushes
//               expected responses; per-DUT monitors pop on every ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, ready0, err0;
  logic [31:0] adr0, wd0, rd0;
  logic        req1, we1, ready1, err1;
  logic [31:0] adr1, wd1, rd1;

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .adr(adr0), .wd(wd0),
    .rd(rd0), .ready(ready0), .err(err0)
  );

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .adr(adr1), .wd(wd1),
    .rd(rd1), .ready(ready1), .err(err1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   pulses0  = 0;
  int   pulses1  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitors: every ready pulse must match the oldest expectation
  always @(negedge clk) begin : mon0
    exp_t e;
    if (reset === 1'b0 && ready0 === 1'b1) begin
      pulses0++;
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_unexpected_ready: got ready=1 expected no response (t=%0t)", $time);
      end else begin
        e = q0.pop_front();
        check("dut0_rd", rd0, e.rd);
        check("dut0_err", {31'd0, err0}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (reset === 1'b0 && ready1 === 1'b1) begin
      pulses1++;
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_ready: got ready=1 expected no response (t=%0t)", $time);
      end else begin
        e = q1.pop_front();
        check("dut1_rd", rd1, e.rd);
        check("dut1_err", {31'd0, err1}, {31'd0, e.err});
      end
    end
  end

  // One transaction. mode 0: normal; 1: change adr/wd the cycle after
  // acceptance (to 0x24/0x22222222); 2: drop req the cycle after acceptance.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                     input logic [31:0] erd, input logic eerr, input int mode);
    exp_t e;
    int   k;
    int   lat_exp;
    logic seen;
    e.rd  = erd;
    e.err = eerr;
    if (d == 0) begin
      q0.push_back(e); req0 = 1'b1; we0 = w; adr0 = a; wd0 = data; lat_exp = 3;
    end else begin
      q1.push_back(e); req1 = 1'b1; we1 = w; adr1 = a; wd1 = data; lat_exp = 1;
    end
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (mode == 1 && k == 1) begin adr0 = 32'h24; wd0 = 32'h2222_2222; end
      if (mode == 2 && k == 1) req0 = 1'b0;
      if (d == 0) seen = (ready0 === 1'b1);
      else        seen = (ready1 === 1'b1);
    end
    if (d == 0) req0 = 1'b0; else req1 = 1'b0;
    check($sformatf("latency_d%0d_a%h", d, a), 32'(k), 32'(lat_exp));
    @(posedge clk); #1;
    if (d == 0) begin
      check("post_ready0", {31'd0, ready0}, 32'd0);
      check("post_rd0", rd0, 32'd0);
      check("post_err0", {31'd0, err0}, 32'd0);
    end else begin
      check("post_ready1", {31'd0, ready1}, 32'd0);
      check("post_rd1", rd1, 32'd0);
      check("post_err1", {31'd0, err1}, 32'd0);
    end
  endtask

  initial begin : stim
    exp_t e;
    int   t[3];
    int   n;
    int   cyc;
    int   p0;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0;
    req1 = 1'b0; we1 = 1'b0; adr1 = '0; wd1 = '0;
    t = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", {31'd0, ready0}, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    check("rst_rd0", rd0, 32'd0);
    check("rst_ready1", {31'd0, ready1}, 32'd0);
    check("rst_err1", {31'd0, err1}, 32'd0);
    check("rst_rd1", rd1, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Basic write / read
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    // Misaligned and out-of-range reads
    txn(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Back-to-back writes with req held high
    e.rd = 32'h0; e.err = 1'b0;
    repeat (3) q0.push_back(e);
    n = 0; cyc = 0;
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h0; wd0 = 32'hA0;
    while (n < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ready0 === 1'b1) begin
        t[n] = cyc;
        n++;
        if (n < 3) begin adr0 = 32'(n * 4); wd0 = 32'hA0 + 32'(n * 4); end
        else req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    check("b2b_count", 32'(n), 32'd3);
    check("b2b_first", 32'(t[0]), 32'd3);
    check("b2b_gap1", 32'(t[1] - t[0]), 32'd4);
    check("b2b_gap2", 32'(t[2] - t[1]), 32'd4);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h0, 32'h0, 32'hA0, 1'b0, 0);
    txn(0, 1'b0, 32'h4, 32'h0, 32'hA4, 1'b0, 0);
    txn(0, 1'b0, 32'h8, 32'h0, 32'hA8, 1'b0, 0);
    // Out-of-range write must not alias onto word 0
    txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 32'h0, 32'h0, 32'hA0, 1'b0, 0);

    // Inputs changed after acceptance are ignored
    txn(0, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
    txn(0, 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, 1);
    txn(0, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 0);
    txn(0, 1'b0, 32'h24, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

    // Reset during WAIT aborts an uncommitted write
    txn(0, 1'b1, 32'h30, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
    p0 = pulses0;
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h30; wd0 = 32'h5555_5555;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready0}, 32'd0);
    check("abort_rd", rd0, 32'd0);
    check("abort_err", {31'd0, err0}, 32'd0);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_pulse", 32'(pulses0), 32'(p0));
    txn(0, 1'b0, 32'h30, 32'h0, 32'h0BAD_F00D, 1'b0, 0);

    // req dropped mid-transaction still completes
    p0 = pulses0;
    txn(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    check("drop_req_one_pulse", 32'(pulses0 - p0), 32'd1);

    // Zero-wait build
    txn(1, 1'b1, 32'h4, 32'h1234_5678, 32'h0, 1'b0, 0);
    txn(1, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0, 0);
    txn(1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_responder
`default_nettype wire
